// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher host: controller states and default sizing.
package xor_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    MSG,
    WAIT,
    READ
  } hostState_e;

  localparam int DefaultWidth   = 8;
  localparam int DefaultTimeout = 255;

endpackage

// File: rtl/xor_cipher_host_slow_clk_sync.sv
// Brings the cipher's slow clock into the system domain and turns its edges
// into single-cycle rise/fall pulses.
module slow_clk_sync (
  input  logic iClk,
  input  logic iRst,
  input  logic iSlowClk,
  output logic oRise,
  output logic oFall
);

  // Bits [1:0] form the synchronizer; bit [2] remembers the previous synchronized level.
  logic [2:0] syncReg;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      syncReg <= '0;
    end else begin
      syncReg <= {syncReg[1:0], iSlowClk};
    end
  end

  assign oRise = syncReg[1] & ~syncReg[2];
  assign oFall = ~syncReg[1] & syncReg[2];

endmodule

// File: rtl/xor_cipher_host.sv
// Host controller: serially loads key and message into the cipher, then reads
// back the serial result and presents it as a parallel word.
module xor_cipher_host
  import xor_cipher_pkg::*;
#(
  parameter int WIDTH   = DefaultWidth,
  parameter int TIMEOUT = DefaultTimeout
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iKey,
  input  logic [WIDTH-1:0] iMsg,
  output logic             oBusy,
  output logic             oValid,
  output logic [WIDTH-1:0] oResult,
  output logic             oError,
  input  logic             iCipher_clk_slow,
  input  logic             iCipher_data,
  input  logic             iCipher_done,
  output logic             oCipher_en,
  output logic             oCipher_data,
  output logic             oCipher_load_key,
  output logic             oCipher_load_msg
);

  localparam int CntW = $clog2(WIDTH + 1);
  localparam int ToW  = $clog2(TIMEOUT + 1);

  hostState_e       state, stateNext;
  logic [WIDTH-1:0] keyReg, keyNext;
  logic [WIDTH-1:0] msgReg, msgNext;
  logic [WIDTH-1:0] shiftReg, shiftNext;
  logic [WIDTH-1:0] resultReg, resultNext;
  logic [CntW-1:0]  bitCnt, bitCntNext;
  logic [ToW-1:0]   toCnt, toCntNext;
  logic             busy, busyNext;
  logic             valid, validNext;
  logic             error, errorNext;
  logic             en, enNext;
  logic             data, dataNext;
  logic             loadKey, loadKeyNext;
  logic             loadMsg, loadMsgNext;

  logic             slowRise, slowFall;
  logic [1:0]       dataSync, doneSync;
  logic [WIDTH-1:0] shiftIn;

  slow_clk_sync slowSync (
    .iClk    (iClk),
    .iRst    (iRst),
    .iSlowClk(iCipher_clk_slow),
    .oRise   (slowRise),
    .oFall   (slowFall)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      dataSync <= '0;
      doneSync <= '0;
    end else begin
      dataSync <= {dataSync[0], iCipher_data};
      doneSync <= {doneSync[0], iCipher_done};
    end
  end

  assign shiftIn = {shiftReg[WIDTH-2:0], dataSync[1]};

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= IDLE;
      keyReg    <= '0;
      msgReg    <= '0;
      shiftReg  <= '0;
      resultReg <= '0;
      bitCnt    <= '0;
      toCnt     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      error     <= 1'b0;
      en        <= 1'b0;
      data      <= 1'b0;
      loadKey   <= 1'b0;
      loadMsg   <= 1'b0;
    end else begin
      state     <= stateNext;
      keyReg    <= keyNext;
      msgReg    <= msgNext;
      shiftReg  <= shiftNext;
      resultReg <= resultNext;
      bitCnt    <= bitCntNext;
      toCnt     <= toCntNext;
      busy      <= busyNext;
      valid     <= validNext;
      error     <= errorNext;
      en        <= enNext;
      data      <= dataNext;
      loadKey   <= loadKeyNext;
      loadMsg   <= loadMsgNext;
    end
  end

  // Key and message are consumed MSB first by shifting their latched copies left.
  always_comb begin
    stateNext   = state;
    keyNext     = keyReg;
    msgNext     = msgReg;
    shiftNext   = shiftReg;
    resultNext  = resultReg;
    bitCntNext  = bitCnt;
    toCntNext   = toCnt;
    busyNext    = busy;
    validNext   = 1'b0;
    errorNext   = 1'b0;
    enNext      = en;
    dataNext    = data;
    loadKeyNext = loadKey;
    loadMsgNext = loadMsg;

    case (state)
      IDLE: begin
        enNext      = 1'b0;
        dataNext    = 1'b0;
        loadKeyNext = 1'b0;
        loadMsgNext = 1'b0;
        busyNext    = 1'b0;
        if (iStart) begin
          keyNext    = iKey;
          msgNext    = iMsg;
          bitCntNext = '0;
          busyNext   = 1'b1;
          stateNext  = KEY;
        end
      end

      KEY: begin
        if (slowFall) begin
          enNext = 1'b1;
          if (bitCnt == CntW'(WIDTH)) begin
            dataNext    = msgReg[WIDTH-1];
            msgNext     = {msgReg[WIDTH-2:0], 1'b0};
            loadKeyNext = 1'b0;
            loadMsgNext = 1'b1;
            bitCntNext  = CntW'(1);
            stateNext   = MSG;
          end else begin
            dataNext    = keyReg[WIDTH-1];
            keyNext     = {keyReg[WIDTH-2:0], 1'b0};
            loadKeyNext = 1'b1;
            bitCntNext  = bitCnt + CntW'(1);
          end
        end
      end

      MSG: begin
        if (slowFall) begin
          if (bitCnt == CntW'(WIDTH)) begin
            dataNext    = 1'b0;
            loadMsgNext = 1'b0;
            toCntNext   = '0;
            stateNext   = WAIT;
          end else begin
            dataNext   = msgReg[WIDTH-1];
            msgNext    = {msgReg[WIDTH-2:0], 1'b0};
            bitCntNext = bitCnt + CntW'(1);
          end
        end
      end

      // The rise that sees done also carries the first result bit.
      WAIT: begin
        if (slowRise) begin
          if (doneSync[1]) begin
            shiftNext  = shiftIn;
            bitCntNext = CntW'(1);
            stateNext  = READ;
          end else if (toCnt == ToW'(TIMEOUT - 1)) begin
            errorNext = 1'b1;
            busyNext  = 1'b0;
            enNext    = 1'b0;
            stateNext = IDLE;
          end else begin
            toCntNext = toCnt + ToW'(1);
          end
        end
      end

      READ: begin
        if (slowRise) begin
          if (!doneSync[1]) begin
            errorNext = 1'b1;
            busyNext  = 1'b0;
            enNext    = 1'b0;
            stateNext = IDLE;
          end else if (bitCnt == CntW'(WIDTH - 1)) begin
            shiftNext  = shiftIn;
            resultNext = shiftIn;
            validNext  = 1'b1;
            busyNext   = 1'b0;
            enNext     = 1'b0;
            stateNext  = IDLE;
          end else begin
            shiftNext  = shiftIn;
            bitCntNext = bitCnt + CntW'(1);
          end
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign oBusy            = busy;
  assign oValid           = valid;
  assign oError           = error;
  assign oResult          = resultReg;
  assign oCipher_en       = en;
  assign oCipher_data     = data;
  assign oCipher_load_key = loadKey;
  assign oCipher_load_msg = loadMsg;

endmodule

// File: tb/tb_xor_cipher_host.sv
// Self-checking bench: a behavioural serial cipher returns key^msg, and a
// scoreboard compares every oValid/oError pulse against queued expectations.
module tb_xor_cipher_host;

  localparam int W = 8;
  localparam int Budget = 20000;
  localparam int ModeNormal = 0;
  localparam int ModeNoDone = 1;
  localparam int ModeDrop   = 2;
  localparam int ModeEarly  = 3;

  typedef struct packed {
    logic         isErr;
    logic [W-1:0] res;
  } expEntry_t;

  logic         iClk = 1'b0;
  logic         iRst = 1'b0;
  logic         iStart = 1'b0;
  logic [W-1:0] iKey = '0;
  logic [W-1:0] iMsg = '0;
  logic         oBusy, oValid, oError;
  logic [W-1:0] oResult;
  logic         slowClk = 1'b0;
  logic         cipherData = 1'b0;
  logic         cipherDone = 1'b0;
  logic         oCipher_en, oCipher_data, oCipher_load_key, oCipher_load_msg;

  int checks = 0;
  int failures = 0;
  int mode = ModeNormal;
  int keyCnt = 0, msgCnt = 0, readCnt = 0, waitRises = 0, errRises = -1;
  logic [W-1:0] capKey = '0, capMsg = '0, refResult = '0;
  logic [W-1:0] resWord;
  expEntry_t expQ[$];

  xor_cipher_host #(.WIDTH(W), .TIMEOUT(255)) dut (
    .iClk            (iClk),
    .iRst            (iRst),
    .iStart          (iStart),
    .iKey            (iKey),
    .iMsg            (iMsg),
    .oBusy           (oBusy),
    .oValid          (oValid),
    .oResult         (oResult),
    .oError          (oError),
    .iCipher_clk_slow(slowClk),
    .iCipher_data    (cipherData),
    .iCipher_done    (cipherDone),
    .oCipher_en      (oCipher_en),
    .oCipher_data    (oCipher_data),
    .oCipher_load_key(oCipher_load_key),
    .oCipher_load_msg(oCipher_load_msg)
  );

  initial forever #5 iClk = ~iClk;
  initial begin
    #3;
    forever #80 slowClk = ~slowClk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic boundFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound of %0d cycles expired", name, Budget);
  endtask

  // Cipher model, sampling side: collects serial key/message bits on slow rises.
  assign resWord = capKey ^ capMsg;

  always @(posedge slowClk) begin
    if (oCipher_en) checkOutput("loadStrobesExclusive", 32'(oCipher_load_key & oCipher_load_msg), 32'd0);
    if (oCipher_en && oCipher_load_key) begin
      waitRises <= 0;
      if (msgCnt != 0 || keyCnt >= W) begin
        keyCnt <= 1;
        msgCnt <= 0;
      end else begin
        keyCnt <= keyCnt + 1;
      end
      capKey <= {capKey[W-2:0], oCipher_data};
    end else if (oCipher_en && oCipher_load_msg) begin
      msgCnt <= msgCnt + 1;
      capMsg <= {capMsg[W-2:0], oCipher_data};
    end else if (oCipher_en && msgCnt == W) begin
      waitRises <= waitRises + 1;
    end
  end

  // Cipher model, update side: presents done and result bits on slow falls.
  always @(negedge slowClk) begin
    if (!oCipher_en) begin
      cipherDone <= 1'b0;
      cipherData <= 1'b0;
      readCnt    <= 0;
    end else if (msgCnt == W) begin
      if (readCnt < W) begin
        cipherData <= resWord[W-1-readCnt];
        readCnt    <= readCnt + 1;
      end
      cipherDone <= (mode == ModeNoDone) ? 1'b0 :
                    (mode == ModeDrop && readCnt >= 3) ? 1'b0 : 1'b1;
    end else if (mode == ModeEarly && keyCnt >= 3) begin
      cipherDone <= 1'b1;
    end
  end

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge iClk) begin : monitor
    expEntry_t e;
    if (iRst && (oValid || oError)) begin
      checkOutput("pulseExclusive", 32'(oValid & oError), 32'd0);
      checkOutput("busyDropsWithPulse", 32'(oBusy), 32'd0);
      if (oError) errRises <= waitRises;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedPulse: got valid=%0b error=%0b with nothing queued", oValid, oError);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulseKind", 32'(oError), 32'(e.isErr));
        checkOutput("result", 32'(oResult), 32'(e.res));
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || oBusy) && n < Budget) begin
      @(negedge iClk);
      n++;
    end
    if (n >= Budget) boundFail("waitIdle");
  endtask

  task automatic applyStimulus(input logic [W-1:0] k, input logic [W-1:0] m, input int md);
    expEntry_t e;
    mode = md;
    if (md == ModeNoDone || md == ModeDrop) begin
      e.isErr = 1'b1;
      e.res   = refResult;
    end else begin
      e.isErr   = 1'b0;
      e.res     = k ^ m;
      refResult = k ^ m;
    end
    expQ.push_back(e);
    @(negedge iClk);
    iKey   = k;
    iMsg   = m;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iKey   = W'($urandom);
    iMsg   = W'($urandom);
    checkOutput("busyAfterStart", 32'(oBusy), 32'd1);
    waitIdle();
    checkOutput("serialKey", 32'(capKey), 32'(k));
    checkOutput("serialMsg", 32'(capMsg), 32'(m));
    checkOutput("resultHeld", 32'(oResult), 32'(refResult));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".oBusy"}, 32'(oBusy), 32'd0);
    checkOutput({tag, ".oValid"}, 32'(oValid), 32'd0);
    checkOutput({tag, ".oError"}, 32'(oError), 32'd0);
    checkOutput({tag, ".oResult"}, 32'(oResult), 32'd0);
    checkOutput({tag, ".oCipher_en"}, 32'(oCipher_en), 32'd0);
    checkOutput({tag, ".oCipher_data"}, 32'(oCipher_data), 32'd0);
    checkOutput({tag, ".oCipher_load_key"}, 32'(oCipher_load_key), 32'd0);
    checkOutput({tag, ".oCipher_load_msg"}, 32'(oCipher_load_msg), 32'd0);
  endtask

  initial begin
    expEntry_t e;
    int n;
    repeat (5) @(negedge iClk);
    checkAllZero("reset");
    iRst = 1'b1;
    repeat (20) @(negedge iClk);

    $display("[TB] basic transaction");
    applyStimulus(8'hA5, 8'h3C, ModeNormal);
    checkOutput("basicResult", 32'(oResult), 32'h99);

    $display("[TB] back-to-back with held start");
    mode = ModeNormal;
    e = '{isErr: 1'b0, res: 8'hF0};
    expQ.push_back(e);
    e = '{isErr: 1'b0, res: 8'h81};
    expQ.push_back(e);
    refResult = 8'h81;
    @(negedge iClk);
    iKey = 8'hFF;
    iMsg = 8'h0F;
    iStart = 1'b1;
    @(negedge iClk);
    checkOutput("busyAfterHeldStart", 32'(oBusy), 32'd1);
    iKey = 8'h00;
    iMsg = 8'h81;
    n = 0;
    while (expQ.size() > 1 && n < Budget) begin @(negedge iClk); n++; end
    if (n >= Budget) boundFail("firstBackToBack");
    n = 0;
    while (!oBusy && n < Budget) begin @(negedge iClk); n++; end
    if (n >= Budget) boundFail("secondBackToBackStart");
    iStart = 1'b0;
    waitIdle();
    checkOutput("b2bSerialKey", 32'(capKey), 32'h00);
    checkOutput("b2bSerialMsg", 32'(capMsg), 32'h81);
    repeat (40) @(negedge iClk);
    checkOutput("noExtraTransaction", 32'(oBusy), 32'd0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 4; i++) applyStimulus(W'($urandom), W'($urandom), ModeNormal);

    $display("[TB] early done");
    applyStimulus(W'($urandom), W'($urandom), ModeEarly);

    $display("[TB] timeout");
    applyStimulus(W'($urandom), W'($urandom), ModeNoDone);
    checkOutput("timeoutRises", 32'(errRises), 32'd255);
    checkOutput("busyAfterTimeout", 32'(oBusy), 32'd0);

    $display("[TB] done drop");
    applyStimulus(W'($urandom), W'($urandom), ModeDrop);
    checkOutput("busyAfterDrop", 32'(oBusy), 32'd0);

    $display("[TB] reset mid-message");
    mode = ModeNormal;
    @(negedge iClk);
    iKey = W'($urandom);
    iMsg = W'($urandom);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    n = 0;
    while (msgCnt != 4 && n < Budget) begin @(negedge iClk); n++; end
    if (n >= Budget) boundFail("reachFourthMsgBit");
    repeat (3) @(negedge iClk);
    #2;
    iRst = 1'b0;
    #1;
    checkAllZero("midReset");
    refResult = '0;
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    repeat (40) @(negedge iClk);
    applyStimulus(8'h12, 8'h34, ModeNormal);
    checkOutput("afterResetResult", 32'(oResult), 32'h26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
